// File: rtl/imm_decode_stage.sv
// Instruction immediate decode stage: decodes format/immediate on entry and
// buffers results in a 2-entry skid buffer (main + skid) with a saturating illegal counter.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  // state | meaning
  // EMPTY | no entry held, out_valid low
  // ONE   | main register holds the head entry
  // FULL  | main holds head, skid holds the next entry; upstream stalled
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } entry_t;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_ILL = 3'd7;

  state_t         state_q, state_d;
  entry_t         main_q, main_d, skid_q, skid_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]    imm32;
  logic           accept, drain;

  always_comb begin
    imm32   = '0;
    dec.ir  = in_ir;
    dec.pc  = in_pc;
    dec.fmt = FMT_ILL;
    if (in_ir[1:0] == 2'b11) begin
      case (in_ir[6:0])
        7'b0110011: dec.fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
          dec.fmt = FMT_I;
          imm32   = {{20{in_ir[31]}}, in_ir[31:20]};
        end
        7'b0100011: begin
          dec.fmt = FMT_S;
          imm32   = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
        end
        7'b1100011: begin
          dec.fmt = FMT_B;
          imm32   = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec.fmt = FMT_U;
          imm32   = {in_ir[31:12], 12'b0};
        end
        7'b1101111: begin
          dec.fmt = FMT_J;
          imm32   = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
        end
        default: dec.fmt = FMT_ILL;
      endcase
    end
    // every 32-bit immediate is already sign-correct at bit 31, so widen by sign
    dec.imm = XLEN'($signed(imm32));
  end

  assign in_ready = !reset && (state_q != FULL);
  assign accept   = in_valid && in_ready;
  assign drain    = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: if (accept) begin
        main_d  = dec;
        state_d = ONE;
      end
      ONE: begin
        if (accept && drain) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: if (drain) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (accept && dec.fmt == FMT_ILL && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
    // flush discards held entries and the offered word, leaving the counter alone
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = (state_q != EMPTY);
  assign out_ir        = main_q.ir;
  assign out_pc        = main_q.pc;
  assign out_imm       = main_q.imm;
  assign out_fmt       = main_q.fmt;
  assign out_illegal   = (main_q.fmt == FMT_ILL);
  assign illegal_count = cnt_q;

endmodule
